// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, drives a 1-cycle-latency ROM and
// presents decoded fields, closing the loop on branch/jump/halt from control.
module fetch_unit #(
  parameter int              PC_W       = 8,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_data,
  input  logic            branch,
  input  logic            jump,
  input  logic            halt,
  input  logic            branch_cond,
  input  logic [7:0]      branch_off,
  input  logic [PC_W-1:0] jump_target,
  output logic            format,
  output logic [3:0]      opcode,
  output logic            sign,
  output logic [2:0]      operand,
  output logic [7:0]      imm,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc_out,
  output logic            halted
);

  // state  | meaning
  // IDLE   | waiting for start, ROM addressed at START_ADDR
  // FILL   | ROM returning START_ADDR, nothing presented yet
  // RUN    | fetching; instr_valid=0 here marks a redirect bubble
  // HALTED | fetch frozen until reset
  typedef enum logic [1:0] {IDLE, FILL, RUN, HALTED} state_t;

  localparam logic [PC_W-1:0] ONE = PC_W'(1);

  state_t          state, state_nx;
  logic [PC_W-1:0] addr_nx, pc_nx;
  logic            valid_nx, halted_nx;
  logic [PC_W+7:0] off_ext;
  logic [PC_W-1:0] target;
  logic            redirect;

  // Sign-extend wide enough for any PC_W, then truncate to PC width (mod 2^PC_W).
  assign off_ext  = {{PC_W{branch_off[7]}}, branch_off};
  assign redirect = jump | (branch & branch_cond);
  assign target   = jump ? jump_target : (pc_out + off_ext[PC_W-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      imem_addr   <= START_ADDR;
      pc_out      <= START_ADDR;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_nx;
      imem_addr   <= addr_nx;
      pc_out      <= pc_nx;
      instr_valid <= valid_nx;
      halted      <= halted_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    addr_nx   = imem_addr;
    pc_nx     = pc_out;
    valid_nx  = instr_valid;
    halted_nx = halted;
    case (state)
      IDLE: begin
        addr_nx   = START_ADDR;
        pc_nx     = START_ADDR;
        valid_nx  = 1'b0;
        halted_nx = 1'b0;
        if (start) state_nx = FILL;
      end
      FILL: begin
        addr_nx  = START_ADDR + ONE;
        pc_nx    = START_ADDR;
        valid_nx = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        if (instr_valid && halt) begin
          state_nx  = HALTED;
          valid_nx  = 1'b0;
          halted_nx = 1'b1;
        end else if (instr_valid && redirect) begin
          // The word already in flight is sequential; drop it for one cycle.
          addr_nx  = target;
          valid_nx = 1'b0;
        end else begin
          addr_nx  = imem_addr + ONE;
          pc_nx    = imem_addr;
          valid_nx = 1'b1;
        end
      end
      HALTED: begin
        valid_nx  = 1'b0;
        halted_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Invalid slots present a NOP so control's default decode applies.
  assign format  = instr_valid ? imem_data[8]   : 1'b1;
  assign opcode  = instr_valid ? imem_data[7:4] : 4'b0110;
  assign sign    = instr_valid ? imem_data[3]   : 1'b0;
  assign operand = instr_valid ? imem_data[2:0] : 3'b000;
  assign imm     = imem_data[7:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model with one-cycle latency, scenario tasks.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset, start, branch, jump, halt, branch_cond;
  logic [7:0] branch_off, jump_target;
  logic [7:0] imem_addr, pc_out, imm;
  logic [8:0] imem_data;
  logic       format, sign, instr_valid, halted;
  logic [3:0] opcode;
  logic [2:0] operand;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.PC_W(8), .START_ADDR(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr),
    .imem_data(imem_data), .branch(branch), .jump(jump), .halt(halt),
    .branch_cond(branch_cond), .branch_off(branch_off), .jump_target(jump_target),
    .format(format), .opcode(opcode), .sign(sign), .operand(operand), .imm(imm),
    .instr_valid(instr_valid), .pc_out(pc_out), .halted(halted)
  );

  always #5 clk = ~clk;

  // ROM word at address a: format=1, opcode=2 (add), low nibble = a[3:0].
  always @(posedge clk) imem_data <= {1'b1, 4'b0010, imem_addr[3:0]};

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_ctl;
    start = 0; branch = 0; jump = 0; halt = 0; branch_cond = 0;
    branch_off = 0; jump_target = 0;
  endtask

  // Reset, start, and leave the first valid instruction (pc 0) presented.
  task automatic boot;
    clear_ctl();
    reset = 1; step(2); reset = 0;
    start = 1; step(); start = 0; step();
  endtask

  task automatic test_reset;
    clear_ctl();
    reset = 1; step(2);
    n_checks++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h exp 00", imem_addr); end
    n_checks++; if (pc_out !== 8'h00) begin n_fail++; $display("FAIL reset_pc got %h exp 00", pc_out); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", halted); end
    n_checks++; if ({format, opcode, sign, operand} !== {1'b1, 4'b0110, 1'b0, 3'b000}) begin
      n_fail++; $display("FAIL reset_fields got %b %b %b %b exp 1 0110 0 000", format, opcode, sign, operand);
    end
    reset = 0; step(3);
    n_checks++; if (instr_valid !== 1'b0 || imem_addr !== 8'h00) begin
      n_fail++; $display("FAIL idle_hold got valid=%b addr=%h exp 0 00", instr_valid, imem_addr);
    end
  endtask

  task automatic test_startup;
    logic [4:0] exp_v = 5'b00111;
    logic [7:0] exp_pc [5] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
    start = 1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (instr_valid !== exp_v[4-i]) begin n_fail++; $display("FAIL start_valid[%0d] got %b exp %b", i, instr_valid, exp_v[4-i]); end
      if (i >= 2) begin
        n_checks++; if (pc_out !== exp_pc[i]) begin n_fail++; $display("FAIL start_pc[%0d] got %h exp %h", i, pc_out, exp_pc[i]); end
        n_checks++; if ({format, opcode, sign, operand} !== {1'b1, 4'b0010, exp_pc[i][3:0]}) begin
          n_fail++; $display("FAIL start_fields[%0d] got %b%b%b%b", i, format, opcode, sign, operand);
        end
      end
      step(); start = 0;
    end
  endtask

  task automatic test_branch;
    // Now at pc 3 after test_startup; advance to pc 5.
    step(2);
    n_checks++; if (pc_out !== 8'h05) begin n_fail++; $display("FAIL br_pre_pc got %h exp 05", pc_out); end
    branch = 1; branch_cond = 1; branch_off = 8'hFD;
    step();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL br_bubble got %b exp 0", instr_valid); end
    // Squashed jump in the bubble must be ignored.
    branch = 0; branch_cond = 0; jump = 1; jump_target = 8'h80;
    step();
    jump = 0;
    n_checks++; if (pc_out !== 8'h02 || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL br_target got pc=%h v=%b exp 02 1", pc_out, instr_valid);
    end
    n_checks++; if (imem_addr !== 8'h03) begin n_fail++; $display("FAIL br_next_addr got %h exp 03", imem_addr); end
    step(3);
    n_checks++; if (pc_out !== 8'h05) begin n_fail++; $display("FAIL br2_pre_pc got %h exp 05", pc_out); end
    branch = 1; branch_cond = 0; branch_off = 8'hFD;
    step();
    clear_ctl();
    n_checks++; if (pc_out !== 8'h06 || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL br_not_taken got pc=%h v=%b exp 06 1", pc_out, instr_valid);
    end
  endtask

  task automatic test_jump_wrap;
    boot(); step(3);
    n_checks++; if (pc_out !== 8'h03) begin n_fail++; $display("FAIL jmp_pre_pc got %h exp 03", pc_out); end
    jump = 1; jump_target = 8'hFE;
    step(); clear_ctl();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL jmp_bubble got %b exp 0", instr_valid); end
    step();
    n_checks++; if (pc_out !== 8'hFE || instr_valid !== 1'b1) begin n_fail++; $display("FAIL jmp_fe got pc=%h v=%b", pc_out, instr_valid); end
    n_checks++; if (sign !== 1'b1 || operand !== 3'd6) begin n_fail++; $display("FAIL jmp_fields got s=%b op=%0d exp 1 6", sign, operand); end
    step();
    n_checks++; if (pc_out !== 8'hFF) begin n_fail++; $display("FAIL jmp_ff got %h exp ff", pc_out); end
    n_checks++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL jmp_wrap_addr got %h exp 00", imem_addr); end
    step();
    n_checks++; if (pc_out !== 8'h00 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL jmp_00 got pc=%h v=%b", pc_out, instr_valid); end
  endtask

  task automatic test_back_to_back;
    boot(); step();
    jump = 1; jump_target = 8'h10;
    step(); clear_ctl();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble1 got %b exp 0", instr_valid); end
    step();
    n_checks++; if (pc_out !== 8'h10 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_t1 got pc=%h v=%b exp 10 1", pc_out, instr_valid); end
    branch = 1; branch_cond = 1; branch_off = 8'h05;
    step(); clear_ctl();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble2 got %b exp 0", instr_valid); end
    step();
    n_checks++; if (pc_out !== 8'h15 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_t2 got pc=%h v=%b exp 15 1", pc_out, instr_valid); end
  endtask

  task automatic test_halt;
    boot(); step(4);
    n_checks++; if (pc_out !== 8'h04) begin n_fail++; $display("FAIL halt_pre_pc got %h exp 04", pc_out); end
    halt = 1; jump = 1; jump_target = 8'h40;
    step(); clear_ctl();
    n_checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_enter got h=%b v=%b exp 1 0", halted, instr_valid);
    end
    for (int i = 0; i < 10; i++) begin
      start = i[0]; halt = 1; jump = 1;
      n_checks++; if (imem_addr !== 8'h05 || pc_out !== 8'h04 || halted !== 1'b1 || instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL halt_frozen[%0d] got addr=%h pc=%h h=%b v=%b exp 05 04 1 0", i, imem_addr, pc_out, halted, instr_valid);
      end
      step();
    end
    clear_ctl();
    reset = 1; step(); reset = 0;
    n_checks++; if (imem_addr !== 8'h00 || halted !== 1'b0 || pc_out !== 8'h00) begin
      n_fail++; $display("FAIL halt_reset got addr=%h h=%b pc=%h exp 00 0 00", imem_addr, halted, pc_out);
    end
    start = 1; step(); start = 0; step();
    n_checks++; if (instr_valid !== 1'b1 || pc_out !== 8'h00) begin
      n_fail++; $display("FAIL halt_restart got v=%b pc=%h exp 1 00", instr_valid, pc_out);
    end
  endtask

  task automatic test_reset_in_bubble;
    boot(); step(2);
    branch = 1; branch_cond = 1; branch_off = 8'h04;
    step(); clear_ctl();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rb_bubble got %b exp 0", instr_valid); end
    reset = 1; jump = 1; jump_target = 8'h40;
    step();
    reset = 0; jump = 0;
    n_checks++; if (imem_addr !== 8'h00 || pc_out !== 8'h00 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL rb_reset got addr=%h pc=%h v=%b h=%b exp 00 00 0 0", imem_addr, pc_out, instr_valid, halted);
    end
    n_checks++; if ({format, opcode, sign, operand} !== {1'b1, 4'b0110, 1'b0, 3'b000}) begin
      n_fail++; $display("FAIL rb_fields got %b %b %b %b", format, opcode, sign, operand);
    end
    step(3);
    n_checks++; if (imem_addr !== 8'h00 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL rb_no_jump got addr=%h v=%b exp 00 0", imem_addr, instr_valid);
    end
  endtask

  initial begin
    clear_ctl();
    reset = 1;
    step();
    test_reset();
    test_startup();
    test_branch();
    test_jump_wrap();
    test_back_to_back();
    test_halt();
    test_reset_in_bubble();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
